// File: rtl/lsu_ctrl.sv
// Load/store unit driving a word-wide data memory port: byte/half extraction on loads,
// read-modify-write for SB/SH. Optional misalignment trapping via LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t      state_r;
    logic [31:0] merge_r;
    logic [31:0] save_addr_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;

    logic        accept_s;
    logic        f3_bad_s;
    logic        range_err_s;
    logic        misalign_s;
    logic        err_s;
    logic        is_sw_s;
    logic [31:0] word_idx_s;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000:  r[{lane, 3'b000} +: 8] = wdata[7:0];
            default: r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        endcase
        return r;
    endfunction

    // Request decode, fault classification and the combinational memory port.
    always_comb begin
        req_ready   = rst_n & (state_r == IDLE);
        accept_s    = req_valid & req_ready;
        word_idx_s  = {2'b00, req_addr[31:2]};
        range_err_s = (word_idx_s >= MEM_WORDS);
        if (req_we) begin
            f3_bad_s = (req_funct3 > 3'b010);
        end else begin
            f3_bad_s = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        err_s   = f3_bad_s | range_err_s | misalign_s;
        is_sw_s = req_we & (req_funct3 == 3'b010);
        if (state_r == RMW_WR) begin
            mem_addr  = save_addr_r;
            mem_wdata = merge_r;
        end else begin
            mem_addr  = {req_addr[31:2], 2'b00};
            mem_wdata = req_wdata;
        end
        // Writes only from SW accept or the second RMW cycle; reset kills both strobes.
        mem_we = rst_n & ((state_r == RMW_WR) | (accept_s & ~err_s & is_sw_s));
        mem_re = rst_n & accept_s & ~err_s & ~is_sw_s;
    end

    // Control state, RMW merge buffer and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            merge_r      <= 32'h0000_0000;
            save_addr_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (err_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else if (!req_we) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_extend(mem_rdata, req_funct3, req_addr[1:0]);
                        end else if (is_sw_s) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            merge_r     <= merge_store(mem_rdata, req_funct3, req_addr[1:0], req_wdata);
                            save_addr_r <= {req_addr[31:2], 2'b00};
                            state_r     <= RMW_WR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RMW_WR: begin
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= 32'h0000_0000;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule
